// File: rtl/ioctl_rom_loader.sv
// ioctl_rom_loader: ROM download front-end from the data_io ioctl byte stream
// to NPORTS toggle-handshake SDRAM write ports. Each byte is decoded into an
// address region, rebased to that region, optionally paired into a 16-bit word,
// and written through a two-entry buffer (one in flight, one pending).
// Writes issue one cycle after the entry is buffered; a new request toggles
// one cycle after the previous ack is seen. Entries arriving with both buffer
// slots occupied are dropped and flagged on overrun.
// Also owns rom_loaded and the registered core reset.
//
// Ports:
//   clk_sys, reset          clock, asynchronous active-high reset
//   ioctl_downl/wr/addr/dout  data_io download stream (write = rising edge of wr)
//   user_reset              OSD/button reset request
//   port_req/port_ack       per-port toggle handshake (done when ack == req)
//   port_a/ds/d/we          shared write address (word, region-relative),
//                           byte enables {hi,lo}, data, write enable
//   busy, rom_loaded, core_reset, overrun, unmapped   status

module ioctl_rom_loader #(
  parameter int                   NPORTS    = 2,
  parameter int                   AW        = 25,
  parameter logic [NPORTS*AW-1:0] PORT_BASE = {25'h40000, 25'h0},
  parameter logic [NPORTS*AW-1:0] PORT_SIZE = {25'h40000, 25'h40000},
  parameter bit                   PACK16    = 1'b0
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_downl,
  input  logic              ioctl_wr,
  input  logic [AW-1:0]     ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              user_reset,
  output logic [NPORTS-1:0] port_req,
  input  logic [NPORTS-1:0] port_ack,
  output logic [AW-2:0]     port_a,
  output logic [1:0]        port_ds,
  output logic [15:0]       port_d,
  output logic              port_we,
  output logic              busy,
  output logic              rom_loaded,
  output logic              core_reset,
  output logic              overrun,
  output logic              unmapped
);

  localparam int CW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  typedef struct packed {
    logic [CW-1:0] chan;
    logic [AW-2:0] a;
    logic [1:0]    ds;
    logic [15:0]   d;
  } entry_t;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  // ---------------------------------------------------------------------------
  // Edge detectors
  // ---------------------------------------------------------------------------
  logic wr_q, downl_q;
  logic wr_rise, downl_rise, downl_fall;

  assign wr_rise    = ioctl_wr & ~wr_q;
  assign downl_rise = ioctl_downl & ~downl_q;
  assign downl_fall = ~ioctl_downl & downl_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_q    <= 1'b0;
      downl_q <= 1'b0;
    end else begin
      wr_q    <= ioctl_wr;
      downl_q <= ioctl_downl;
    end
  end

  // ---------------------------------------------------------------------------
  // Region decode: scan from the top so the lowest matching region wins.
  // One extra bit keeps base+size from wrapping at the top of the space.
  // ---------------------------------------------------------------------------
  logic          hit;
  logic [CW-1:0] hit_chan;
  logic [AW-1:0] rel;
  logic [AW:0]   addr_ext, reg_lo, reg_hi;

  always_comb begin
    hit      = 1'b0;
    hit_chan = '0;
    rel      = '0;
    reg_lo   = '0;
    reg_hi   = '0;
    addr_ext = {1'b0, ioctl_addr};
    for (int i = NPORTS - 1; i >= 0; i--) begin
      reg_lo = {1'b0, PORT_BASE[i*AW +: AW]};
      reg_hi = reg_lo + {1'b0, PORT_SIZE[i*AW +: AW]};
      if (addr_ext >= reg_lo && addr_ext < reg_hi) begin
        hit      = 1'b1;
        hit_chan = CW'(i);
        rel      = ioctl_addr - PORT_BASE[i*AW +: AW];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Entry formation (byte lanes or 16-bit packing)
  // ---------------------------------------------------------------------------
  logic          lo_vld;
  logic [CW-1:0] lo_chan;
  logic [AW-2:0] lo_a;
  logic [7:0]    lo_byte;

  logic   in_vld, lo_load, lo_clr, unm_evt;
  entry_t in_e, byte_e, flush_e;

  always_comb begin
    byte_e.chan  = hit_chan;
    byte_e.a     = rel[AW-1:1];
    byte_e.ds    = {rel[0], ~rel[0]};
    byte_e.d     = {ioctl_dout, ioctl_dout};
    flush_e.chan = lo_chan;
    flush_e.a    = lo_a;
    flush_e.ds   = 2'b01;
    flush_e.d    = {lo_byte, lo_byte};
    in_vld  = 1'b0;
    in_e    = byte_e;
    lo_load = 1'b0;
    lo_clr  = 1'b0;
    unm_evt = 1'b0;
    if (wr_rise && !hit) begin
      unm_evt = 1'b1;
    end else if (wr_rise) begin
      if (!PACK16) begin
        in_vld = 1'b1;
      end else if (!rel[0]) begin
        // Even byte: any older unpaired low byte is flushed first.
        in_vld  = lo_vld;
        in_e    = flush_e;
        lo_load = 1'b1;
      end else if (lo_vld && lo_chan == hit_chan && lo_a == rel[AW-1:1]) begin
        in_vld  = 1'b1;
        in_e.ds = 2'b11;
        in_e.d  = {ioctl_dout, lo_byte};
        lo_clr  = 1'b1;
      end else begin
        in_vld = 1'b1;
      end
    end else if (PACK16 && lo_vld && !ioctl_downl) begin
      // Download ended with a dangling low byte: write it alone.
      in_vld = 1'b1;
      in_e   = flush_e;
      lo_clr = 1'b1;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      lo_vld  <= 1'b0;
      lo_chan <= '0;
      lo_a    <= '0;
      lo_byte <= '0;
    end else if (lo_load) begin
      lo_vld  <= 1'b1;
      lo_chan <= hit_chan;
      lo_a    <= rel[AW-1:1];
      lo_byte <= ioctl_dout;
    end else if (lo_clr) begin
      lo_vld  <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Two-slot buffer: e0 is the head (in flight once issued), e1 waits behind.
  // ---------------------------------------------------------------------------
  logic   v0, v1;
  entry_t e0, e1;
  logic   ack_match, issue, pop, push, drop;
  state_t state_q, state_d;

  always_comb begin
    ack_match = 1'b0;
    for (int i = 0; i < NPORTS; i++) begin
      if (e0.chan == CW'(i)) ack_match = (port_ack[i] == port_req[i]);
    end
  end

  // FSM: state register
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (v0) state_d = S_WAIT;
      S_WAIT:  if (ack_match) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    issue = (state_q == S_IDLE) && v0;
    pop   = (state_q == S_WAIT) && ack_match;
  end

  // An ack in the same cycle frees a slot, so the arriving entry still fits.
  assign drop = in_vld & v0 & v1 & ~pop;
  assign push = in_vld & ~drop;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
      e0 <= '0;
      e1 <= '0;
    end else if (pop) begin
      if (v1) begin
        e0 <= e1;
        if (push) e1 <= in_e;
        else      v1 <= 1'b0;
      end else begin
        if (push) e0 <= in_e;
        v0 <= push;
      end
    end else if (push) begin
      if (!v0) begin
        e0 <= in_e;
        v0 <= 1'b1;
      end else begin
        e1 <= in_e;
        v1 <= 1'b1;
      end
    end
  end

  // Write port registers only change on issue, so they hold until the ack.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      port_req <= '0;
      port_a   <= '0;
      port_ds  <= '0;
      port_d   <= '0;
    end else if (issue) begin
      port_a  <= e0.a;
      port_ds <= e0.ds;
      port_d  <= e0.d;
      for (int i = 0; i < NPORTS; i++) begin
        if (e0.chan == CW'(i)) port_req[i] <= ~port_req[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Status and core reset
  // ---------------------------------------------------------------------------
  logic seen_fall;

  assign busy    = v0 | v1 | lo_vld;
  assign port_we = ioctl_downl;

  // New events win over the clear at download start so they are never lost.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      seen_fall  <= 1'b0;
      rom_loaded <= 1'b0;
      overrun    <= 1'b0;
      unmapped   <= 1'b0;
      core_reset <= 1'b1;
    end else begin
      seen_fall  <= downl_rise ? 1'b0 : (seen_fall | downl_fall);
      rom_loaded <= downl_rise ? 1'b0 : (rom_loaded | (seen_fall & ~busy));
      overrun    <= (overrun & ~downl_rise) | drop;
      unmapped   <= (unmapped & ~downl_rise) | unm_evt;
      core_reset <= user_reset | ~rom_loaded;
    end
  end

endmodule

// File: tb/tb_ioctl_rom_loader.sv
// Bench for ioctl_rom_loader: one byte-lane instance and one PACK16 instance
// share the ioctl stimulus; each has its own randomized ack responder.
module tb_ioctl_rom_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, downl, wr, user_reset;
  logic [24:0] addr;
  logic [7:0]  dout;
  logic [1:0]  ack    [2];
  logic [1:0]  req    [2];
  logic [23:0] pa     [2];
  logic [1:0]  ds     [2];
  logic [15:0] pd     [2];
  logic        we     [2];
  logic        busy   [2];
  logic        loaded [2];
  logic        creset [2];
  logic        ovr    [2];
  logic        unm    [2];

  ioctl_rom_loader #(.NPORTS(2), .AW(25), .PACK16(1'b0)) u0 (
    .clk_sys(clk), .reset(reset), .ioctl_downl(downl), .ioctl_wr(wr),
    .ioctl_addr(addr), .ioctl_dout(dout), .user_reset(user_reset),
    .port_req(req[0]), .port_ack(ack[0]), .port_a(pa[0]), .port_ds(ds[0]),
    .port_d(pd[0]), .port_we(we[0]), .busy(busy[0]), .rom_loaded(loaded[0]),
    .core_reset(creset[0]), .overrun(ovr[0]), .unmapped(unm[0]));

  ioctl_rom_loader #(.NPORTS(2), .AW(25), .PACK16(1'b1)) u1 (
    .clk_sys(clk), .reset(reset), .ioctl_downl(downl), .ioctl_wr(wr),
    .ioctl_addr(addr), .ioctl_dout(dout), .user_reset(user_reset),
    .port_req(req[1]), .port_ack(ack[1]), .port_a(pa[1]), .port_ds(ds[1]),
    .port_d(pd[1]), .port_we(we[1]), .busy(busy[1]), .rom_loaded(loaded[1]),
    .core_reset(creset[1]), .overrun(ovr[1]), .unmapped(unm[1]));

  typedef struct {
    int          chan;
    logic [23:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   pushed  [2] = '{0, 0};
  int   acked   [2] = '{0, 0};
  int   req_cnt [2] = '{0, 0};
  bit   exp_ovr [2] = '{0, 0};
  bit   exp_unm [2] = '{0, 0};
  bit   hold_ack = 1'b0;
  // Reference low-byte holder for the packing instance
  bit          lo_v = 1'b0;
  int          lo_ch = 0;
  logic [23:0] lo_w = '0;
  logic [7:0]  lo_b = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Region map: [0,0x40000) -> port 0, [0x40000,0x80000) -> port 1
  function automatic int decode(input logic [24:0] a, output logic [24:0] r);
    int unsigned base [2];
    int unsigned size [2];
    int unsigned av;
    base[0] = 32'h0;     size[0] = 32'h40000;
    base[1] = 32'h40000; size[1] = 32'h40000;
    av = 32'(a);
    for (int i = 0; i < 2; i++) begin
      if (av >= base[i] && av < base[i] + size[i]) begin
        r = 25'(av - base[i]);
        return i;
      end
    end
    r = '0;
    return -1;
  endfunction

  // Two buffer slots: a third outstanding entry is lost.
  task automatic offer(input int k, input int ch, input logic [23:0] a,
                       input logic [1:0] dsv, input logic [15:0] dv);
    exp_t e;
    if (pushed[k] - acked[k] >= 2) begin
      exp_ovr[k] = 1'b1;
      return;
    end
    e.chan = ch; e.a = a; e.ds = dsv; e.d = dv;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
    pushed[k]++;
  endtask

  task automatic model_byte(input logic [24:0] a, input logic [7:0] b);
    logic [24:0] r;
    logic [23:0] w;
    int ch;
    ch = decode(a, r);
    if (ch < 0) begin
      exp_unm[0] = 1'b1;
      exp_unm[1] = 1'b1;
      return;
    end
    w = r[24:1];
    offer(0, ch, w, r[0] ? 2'b10 : 2'b01, {b, b});
    if (!r[0]) begin
      if (lo_v) offer(1, lo_ch, lo_w, 2'b01, {lo_b, lo_b});
      lo_v = 1'b1; lo_ch = ch; lo_w = w; lo_b = b;
    end else if (lo_v && lo_ch == ch && lo_w == w) begin
      offer(1, ch, w, 2'b11, {b, lo_b});
      lo_v = 1'b0;
    end else begin
      offer(1, ch, w, 2'b10, {b, b});
    end
  endtask

  // Monitor + ack responder for instance k
  task automatic serve(input int k);
    logic [1:0] last = 2'b00;
    logic [1:0] diff;
    bit   active = 1'b0;
    bit   has_e = 1'b0;
    int   cnt = 0;
    int   ch = 0;
    exp_t e;
    ack[k] = 2'b00;
    forever begin
      @(negedge clk);
      if (reset) begin
        ack[k] = 2'b00;
        last   = 2'b00;
        active = 1'b0;
        continue;
      end
      if (req[k] !== last) begin
        diff = req[k] ^ last;
        chk($sformatf("req_onehot%0d", k), $countones(diff), 1);
        chk($sformatf("req_while_outstanding%0d", k), 32'(active), 0);
        ch = diff[1] ? 1 : 0;
        req_cnt[k]++;
        has_e = 1'b0;
        if (k == 0 && q0.size() > 0) begin e = q0.pop_front(); has_e = 1'b1; end
        if (k == 1 && q1.size() > 0) begin e = q1.pop_front(); has_e = 1'b1; end
        if (!has_e) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_req%0d: got chan %0d a=0x%0h, expected no request", k, ch, pa[k]);
        end else begin
          chk($sformatf("chan%0d", k), ch, e.chan);
          chk($sformatf("port_a%0d", k), pa[k], e.a);
          chk($sformatf("port_ds%0d", k), ds[k], e.ds);
          chk($sformatf("port_d%0d", k), pd[k], e.d);
        end
        last   = req[k];
        active = 1'b1;
        cnt    = $urandom_range(0, 3);
      end else if (active) begin
        if (has_e) begin
          chk($sformatf("hold_a%0d", k), pa[k], e.a);
          chk($sformatf("hold_d%0d", k), pd[k], e.d);
        end
        if (cnt > 0) cnt--;
        else if (!hold_ack) begin
          ack[k][ch] = req[k][ch];
          acked[k]++;
          active = 1'b0;
        end
      end
    end
  endtask

  initial serve(0);
  initial serve(1);

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_byte(input logic [24:0] a, input logic [7:0] b);
    @(negedge clk);
    addr = a; dout = b; wr = 1'b1;
    model_byte(a, b);
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic dl_rise();
    @(negedge clk);
    downl = 1'b1;
    exp_ovr = '{0, 0};
    exp_unm = '{0, 0};
    gap(2);
  endtask

  task automatic dl_fall();
    @(negedge clk);
    downl = 1'b0;
    if (lo_v) offer(1, lo_ch, lo_w, 2'b01, {lo_b, lo_b});
    lo_v = 1'b0;
  endtask

  task automatic check_flags();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("overrun%0d", k), 32'(ovr[k]), 32'(exp_ovr[k]));
      chk($sformatf("unmapped%0d", k), 32'(unm[k]), 32'(exp_unm[k]));
    end
  endtask

  // rom_loaded must rise after drain and core_reset must follow one cycle later
  task automatic wait_loaded();
    int st [2] = '{0, 0};
    for (int n = 0; n < 1000 && !(st[0] == 2 && st[1] == 2); n++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (st[k] == 0 && loaded[k] === 1'b1) begin
          chk($sformatf("core_reset_lag%0d", k), 32'(creset[k]), 1);
          chk($sformatf("busy_at_loaded%0d", k), 32'(busy[k]), 0);
          st[k] = 1;
        end else if (st[k] == 1) begin
          chk($sformatf("core_reset_fall%0d", k), 32'(creset[k]), 0);
          st[k] = 2;
        end
      end
    end
    for (int k = 0; k < 2; k++) chk($sformatf("load_timeout%0d", k), st[k], 2);
    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((busy[0] !== 1'b0 || busy[1] !== 1'b0 || q0.size() != 0 || q1.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(n < 2000), 1);
  endtask

  task automatic check_reset(input int k);
    chk($sformatf("rst_req%0d", k), req[k], 0);
    chk($sformatf("rst_a%0d", k), pa[k], 0);
    chk($sformatf("rst_ds%0d", k), ds[k], 0);
    chk($sformatf("rst_d%0d", k), pd[k], 0);
    chk($sformatf("rst_busy%0d", k), 32'(busy[k]), 0);
    chk($sformatf("rst_loaded%0d", k), 32'(loaded[k]), 0);
    chk($sformatf("rst_core_reset%0d", k), 32'(creset[k]), 1);
    chk($sformatf("rst_overrun%0d", k), 32'(ovr[k]), 0);
    chk($sformatf("rst_unmapped%0d", k), 32'(unm[k]), 0);
    chk($sformatf("rst_we%0d", k), 32'(we[k]), 0);
  endtask

  initial begin
    int rc [2];
    logic [24:0] ra;
    reset = 1'b1; downl = 1'b0; wr = 1'b0; addr = '0; dout = '0; user_reset = 1'b0;
    gap(3);
    for (int k = 0; k < 2; k++) check_reset(k);
    @(posedge clk); #2 reset = 1'b0;

    // Directed download: byte lanes, pairing, flushes
    dl_rise();
    chk("we_follows_downl", 32'(we[0]), 1);
    write_byte(25'h00003, 8'hA5); gap(10);
    write_byte(25'h40002, 8'h3C); gap(10);
    write_byte(25'h00010, 8'h11); gap(10);
    write_byte(25'h00011, 8'h22); gap(10);
    write_byte(25'h00020, 8'h77); gap(10);
    chk("busy_lo_pending", 32'(busy[1]), 1);
    dl_fall();
    wait_loaded();
    check_flags();

    // User reset forces the core reset for as long as it is held
    @(negedge clk) user_reset = 1'b1;
    @(negedge clk) chk("user_reset_on", 32'(creset[0]), 1);
    user_reset = 1'b0;
    @(negedge clk) chk("user_reset_off", 32'(creset[0]), 0);

    // Overrun: ack held while three entries arrive
    dl_rise();
    chk("loaded_cleared", 32'(loaded[0]), 0);
    hold_ack = 1'b1;
    rc[0] = req_cnt[0]; rc[1] = req_cnt[1];
    write_byte(25'h00101, 8'h5A); gap(3);
    write_byte(25'h00203, 8'h6B); gap(3);
    write_byte(25'h00305, 8'h7C);
    gap(100);
    check_flags();
    for (int k = 0; k < 2; k++) chk($sformatf("busy_held%0d", k), 32'(busy[k]), 1);
    hold_ack = 1'b0;
    wait_drain();
    for (int k = 0; k < 2; k++) chk($sformatf("req_count%0d", k), req_cnt[k] - rc[k], 2);
    dl_fall();
    wait_loaded();

    // Randomized download; new download clears the sticky flags
    dl_rise();
    check_flags();
    for (int i = 0; i < 40; i++) begin
      ra = 25'($urandom_range(0, 32'h7FFFF));
      if ($urandom_range(0, 1) == 1) begin
        ra[0] = 1'b0;
        write_byte(ra, 8'($urandom));
        gap($urandom_range(7, 12));
        ra[0] = 1'b1;
      end
      write_byte(ra, 8'($urandom));
      gap($urandom_range(7, 12));
    end
    dl_fall();
    wait_loaded();
    check_flags();

    // Unmapped byte, then reset while a write is outstanding
    dl_rise();
    write_byte(25'h90000, 8'h55); gap(5);
    check_flags();
    for (int k = 0; k < 2; k++) chk($sformatf("busy_unmapped%0d", k), 32'(busy[k]), 0);
    hold_ack = 1'b1;
    gap(1);
    write_byte(25'h00005, 8'h99); gap(6);
    for (int k = 0; k < 2; k++) chk($sformatf("busy_wait%0d", k), 32'(busy[k]), 1);
    @(posedge clk); #2 reset = 1'b1; downl = 1'b0;
    gap(2);
    for (int k = 0; k < 2; k++) check_reset(k);
    q0.delete(); q1.delete();
    pushed[0] = acked[0]; pushed[1] = acked[1];
    lo_v = 1'b0;
    exp_ovr = '{0, 0};
    exp_unm = '{0, 0};
    hold_ack = 1'b0;
    @(posedge clk); #2 reset = 1'b0;

    // Recovery after reset: handshake restarts from req = ack = 0
    dl_rise();
    write_byte(25'h40001, 8'hC3); gap(10);
    write_byte(25'h00004, 8'h42); gap(10);
    dl_fall();
    wait_loaded();
    check_flags();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
